// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - instruction fetch stage with single-outstanding imem port and IF/ID register
module riscv_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] Instruction_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_plus4_o,
    output logic        Valid_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4_out;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_buf_pc_plus4;
    logic [31:0] w_redirect_pc;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_buf_pc_plus4 = r_buf_pc + 32'd4;
    assign w_redirect_pc  = redirect_pc_i & ~32'd3;

    // The memory shares rst_i, so any in-flight request is simply abandoned on reset.
    assign imem_req_o  = !rst_i && (r_state != S_HOLD);
    assign imem_addr_o = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign Instruction_o = r_instr;
    assign PC_o          = r_pc_out;
    assign PC_plus4_o    = r_pc4_out;
    assign Valid_o       = r_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC_ALIGNED;
            r_drop_addr <= 32'd0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'd0;
            r_instr     <= NOP_INSTR;
            r_pc_out    <= 32'd0;
            r_pc4_out   <= 32'd0;
            r_valid     <= 1'b0;
        end else if (redirect_i) begin
            r_instr     <= NOP_INSTR;
            r_valid     <= 1'b0;
            r_pc        <= w_redirect_pc;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'd0;
            case (r_state)
                S_FETCH: begin
                    // Without an ack the old request must run to completion, so remember its address.
                    if (!imem_ack_i) begin
                        r_drop_addr <= r_pc;
                        r_state     <= S_DROP;
                    end
                end
                S_HOLD:  r_state <= S_FETCH;
                S_DROP:  r_state <= S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        r_pc <= w_pc_plus4;
                        if (!stall_i) begin
                            r_instr   <= imem_rdata_i;
                            r_pc_out  <= r_pc;
                            r_pc4_out <= w_pc_plus4;
                            r_valid   <= 1'b1;
                        end else begin
                            r_buf_instr <= imem_rdata_i;
                            r_buf_pc    <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end else if (!stall_i) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        r_instr     <= r_buf_instr;
                        r_pc_out    <= r_buf_pc;
                        r_pc4_out   <= w_buf_pc_plus4;
                        r_valid     <= 1'b1;
                        r_buf_instr <= NOP_INSTR;
                        r_state     <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        r_state <= S_FETCH;
                    end
                    if (!stall_i) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - directed self-checking bench for riscv_fetch
module tb_riscv_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XK  = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_valid;

    int unsigned lat = 1;
    int unsigned cnt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Memory model: ack on the lat-th cycle of a request, data = address ^ XK.
    assign ack   = req && (cnt >= lat - 1);
    assign rdata = addr ^ XK;

    always @(posedge clk) begin
        if (rst || !req || ack) cnt <= 0;
        else                    cnt <= cnt + 1;
    end

    riscv_fetch u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .Instruction_o(instr),
        .PC_o         (pc),
        .PC_plus4_o   (pc4),
        .Valid_o      (valid)
    );

    riscv_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (1'b0),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'd0),
        .imem_req_o   (w_req),
        .imem_addr_o  (w_addr),
        .imem_ack_i   (w_req),
        .imem_rdata_i (w_addr ^ XK),
        .Instruction_o(w_instr),
        .PC_o         (w_pc),
        .PC_plus4_o   (w_pc4),
        .Valid_o      (w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("c1_req", {31'd0, req}, 32'd1);
        chk("c1_addr", addr, 32'd0);
        chk("w_addr0", w_addr, 32'hFFFF_FFF8);

        tick();
        chk("c2_valid", {31'd0, valid}, 32'd1);
        chk("c2_pc", pc, 32'd0);
        chk("c2_instr", instr, 32'd0 ^ XK);
        chk("c2_pc4", pc4, 32'd4);
        chk("w_pc_a", w_pc, 32'hFFFF_FFF8);
        chk("w_pc4_a", w_pc4, 32'hFFFF_FFFC);

        tick();
        chk("c3_pc", pc, 32'd4);
        chk("c3_addr", addr, 32'd8);
        chk("w_pc_b", w_pc, 32'hFFFF_FFFC);
        chk("w_pc4_b", w_pc4, 32'd0);

        // Stall for two cycles while the fetch of 0x8 completes.
        stall = 1'b1;
        tick();
        chk("w_pc_c", w_pc, 32'd0);
        chk("w_pc4_c", w_pc4, 32'd4);
        chk("hold_req", {31'd0, req}, 32'd0);
        chk("hold_pc", pc, 32'd4);
        tick();
        chk("hold2_pc", pc, 32'd4);
        chk("hold2_valid", {31'd0, valid}, 32'd1);
        stall = 1'b0;
        tick();
        chk("unhold_pc", pc, 32'd8);
        chk("unhold_instr", instr, 32'd8 ^ XK);
        chk("unhold_pc4", pc4, 32'hC);
        chk("unhold_addr", addr, 32'hC);
        tick();
        chk("next_pc", pc, 32'hC);
        chk("next_instr", instr, 32'hC ^ XK);

        // Three-cycle ack latency with a redirect during the wait.
        lat = 3;
        tick();
        chk("wait_valid", {31'd0, valid}, 32'd0);
        chk("wait_addr", addr, 32'h10);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("drop_addr", addr, 32'h10);
        chk("drop_req", {31'd0, req}, 32'd1);
        chk("drop_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("tgt_addr", addr, 32'h100);
        chk("tgt_valid0", {31'd0, valid}, 32'd0);
        tick();
        chk("tgt_valid1", {31'd0, valid}, 32'd0);
        tick();
        chk("tgt_valid2", {31'd0, valid}, 32'd0);
        chk("tgt_addr2", addr, 32'h100);
        tick();
        chk("tgt_pc", pc, 32'h100);
        chk("tgt_instr", instr, 32'h100 ^ XK);
        chk("tgt_valid", {31'd0, valid}, 32'd1);

        // Redirect together with stall to an unaligned target.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        lat = 1;
        chk("rs_valid", {31'd0, valid}, 32'd0);
        chk("rs_instr", instr, NOP);
        chk("rs_addr_old", addr, 32'h104);
        tick();
        chk("rs_addr_new", addr, 32'h200);
        chk("rs_req", {31'd0, req}, 32'd1);
        tick();
        chk("rs_pc", pc, 32'h200);
        chk("rs_valid2", {31'd0, valid}, 32'd1);

        // Reset while a request is waiting for its ack.
        lat = 3;
        tick();
        chk("mw_valid", {31'd0, valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mw_req_rst", {31'd0, req}, 32'd0);
        tick();
        chk("mw_instr", instr, NOP);
        chk("mw_pc", pc, 32'd0);
        chk("mw_valid_rst", {31'd0, valid}, 32'd0);
        chk("mw_req", {31'd0, req}, 32'd0);
        rst = 1'b0;
        lat = 1;
        #1;
        chk("mw_req_after", {31'd0, req}, 32'd1);
        chk("mw_addr_after", addr, 32'd0);
        tick();
        chk("mw_pc_after", pc, 32'd0);
        chk("mw_valid_after", {31'd0, valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
